ad9854_reg_reader: RTL and testbench
====================================

Name: ad9854_reg_reader

Overview:
- Read-back controller for the AD9854 8-bit parallel port: the reading side of the same A/D/WR/RD/UDCLK bus the DDS writer drives.
- On request, it takes bus ownership from the writer through a req/gnt handshake and releases the FPGA data-bus drivers.
- It strobes RD for 1..6 consecutive register addresses and assembles the returned bytes MSB-first into a 48-bit word, e.g. the frequency tuning word (FTW) read back from FTW1 at 0x04..0x09.
- It sits beside the AD9854 writer under myDDS; the top level muxes A, RD and the D tristate.

Parameters:
- TURN_CYC, 1, cycles between bus release (D_oe low) and the first RD fall; range 1..15.
- RD_LOW_CYC, 3, cycles RD is held low per byte; D is sampled on the last low cycle; range 1..15.
- RD_HIGH_CYC, 2, cycles RD is held high between bytes; must be 2 or more.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle read request; sampled only in IDLE
- base_addr  in  6  first register address
- byte_cnt  in  3  number of bytes to read; 1..6 valid, 0 and 7 handled as specified under Behaviour
- bus_req  out  1  requests the AD9854 bus from the writer
- bus_gnt  in  1  writer has parked its bus (WR high, not driving D)
- A  out  6  register address; the top-level mux uses it while bus_req=1
- RD  out  1  active-low read strobe
- D_in  in  8  AD9854 data pins (input side of the tristate)
- D_oe  out  1  1 = FPGA may drive D; 0 = reader owns D as input
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when rdata is valid
- rdata  out  48  assembled read word, right-justified

Behaviour:
- Reset values: bus_req=0, A=0, RD=1, D_oe=1, busy=0, done=0, rdata=0, FSM in IDLE. Asserting rst_n mid-transaction forces these values immediately (asynchronous). No partial rdata is kept and no done is issued.
- States: IDLE, REQ, TURN, STROBE, HOLD, DONE.
- IDLE:
  - start=1 with byte_cnt in 1..6: latch base_addr into A and byte_cnt into the remaining-byte counter, clear rdata, set busy=1, go to REQ.
  - byte_cnt=7 is clamped to 6.
  - byte_cnt=0: go directly to DONE. No bus activity; rdata=0.
- REQ: bus_req=1; wait for bus_gnt=1, with no timeout. bus_gnt high in the same cycle as the start edge is accepted on the next cycle.
- TURN: D_oe=0, RD=1, A stable, for TURN_CYC cycles; then go to STROBE.
- STROBE:
  - RD=0 for RD_LOW_CYC cycles.
  - On the final cycle edge: rdata <= {rdata[39:0], D_in}, decrement the remaining-byte counter, go to HOLD.
- HOLD:
  - RD=1 for RD_HIGH_CYC cycles.
  - A <= A+1 (modulo 64, so 0x3F wraps to 0x00) on the edge ending the first HOLD cycle. This guarantees at least 1 cycle of address setup before the next RD fall.
  - At HOLD exit: go to STROBE if bytes remain, otherwise DONE.
- DONE:
  - One cycle: done=1, D_oe=1, bus_req=0, busy falls on the next edge, return to IDLE.
  - rdata holds until the next accepted start.
- Byte order: the first byte read (base_addr) ends up as the most significant of the N bytes; rdata[8N-1:0] is valid and the upper bits are 0.
- Bus_gnt deasserted during TURN/STROBE/HOLD is ignored: the transaction completes. The writer must not revoke the grant while bus_req=1.
- start while busy is ignored and not queued.
- Latency: done is asserted TURN_CYC + N*(RD_LOW_CYC+RD_HIGH_CYC) cycles after the first cycle in which REQ sees bus_gnt=1. With defaults and N=6 this is 31 cycles.
- RD never glitches: it is driven from a register.
- A and D_oe change only on clk edges.

Test Plan:
- Full FTW read: bench model holds 0x04..0x09 = 01 23 45 67 89 AB; start with base_addr=0x04, byte_cnt=6, bus_gnt=1 -> six RD low pulses of 3 cycles each; A sequence 04..09; rdata=48'h0123_4567_89AB; done 31 cycles after grant; D_oe low throughout.
- Short read: base_addr=0x1D, byte_cnt=2, model 0x1D=0x10, 0x1E=0x64 -> rdata=48'h0000_0000_1064; two RD pulses.
- Wrap and clamp: base_addr=0x3E, byte_cnt=7 (clamped to 6) -> A sequence 3E,3F,00,01,02,03; six bytes captured.
- Handshake: hold bus_gnt=0 for 20 cycles after start -> bus_req=1, RD=1, D_oe=1 throughout the wait; the transfer starts TURN_CYC cycles after bus_gnt rises; a second start pulse during busy produces no extra transfer.
- Reset mid-read: assert rst_n=0 during the third STROBE -> RD=1, D_oe=1, bus_req=0 within the same cycle (asynchronous); no done pulse; after release, a fresh 6-byte read returns correct data.
- Zero count: byte_cnt=0 -> done pulses 1 cycle after start; no RD pulse, bus_req stays 0, rdata=0.

Source files
------------

// File: rtl/ad9854_reg_reader.sv
// Read-back controller for the AD9854 8-bit parallel port.
// Borrows the shared A/D/RD bus from the DDS writer through a req/gnt
// handshake, strobes RD over 1..6 consecutive register addresses and packs the
// returned bytes MSB-first into a right-justified 48-bit word.
module ad9854_reg_reader #(
    parameter int TURN_CYC    = 1,  // bus release to first RD fall, 1..15
    parameter int RD_LOW_CYC  = 3,  // RD low time per byte, 1..15
    parameter int RD_HIGH_CYC = 2   // RD high time between bytes, 2..15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  base_addr,
    input  logic [2:0]  byte_cnt,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [5:0]  A,
    output logic        RD,
    input  logic [7:0]  D_in,
    output logic        D_oe,
    output logic        busy,
    output logic        done,
    output logic [47:0] rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_TURN,
        S_STROBE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [3:0] cyc_cnt;     // cycles left in the current timed phase, minus one
    logic [2:0] bytes_left;  // bytes still to strobe
    logic [2:0] req_cnt;     // requested byte count after clamping 7 to 6
    logic       cyc_last;

    assign cyc_last = (cyc_cnt == 4'd0);
    assign req_cnt  = (byte_cnt == 3'd7) ? 3'd6 : byte_cnt;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            // NOTE: every clocked assignment is non-blocking so all flops
            // sample the same pre-edge values regardless of statement order.
            state <= next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default first so no path through the case leaves next_state
        // unassigned, which would otherwise infer a latch.
        next_state = state;
        case (state)
            S_IDLE:   if (start) next_state = (req_cnt == 3'd0) ? S_DONE : S_REQ;
            S_REQ:    if (bus_gnt) next_state = S_TURN;
            S_TURN:   if (cyc_last) next_state = S_STROBE;
            S_STROBE: if (cyc_last) next_state = S_HOLD;
            S_HOLD:   if (cyc_last) next_state = (bytes_left != 3'd0) ? S_STROBE : S_DONE;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Phase timer: reloaded on every state change, counts down to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
        end else if (state != next_state) begin
            case (next_state)
                S_TURN:   cyc_cnt <= 4'(TURN_CYC - 1);
                S_STROBE: cyc_cnt <= 4'(RD_LOW_CYC - 1);
                S_HOLD:   cyc_cnt <= 4'(RD_HIGH_CYC - 1);
                default:  cyc_cnt <= '0;
            endcase
        end else if (!cyc_last) begin
            cyc_cnt <= cyc_cnt - 4'd1;
        end
    end

    // Address, byte counter and read-word datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A          <= '0;
            bytes_left <= '0;
            rdata      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        A          <= base_addr;
                        bytes_left <= req_cnt;
                        rdata      <= '0;
                    end
                end
                S_STROBE: begin
                    // D is sampled on the last RD-low cycle, oldest byte ends up on top.
                    if (cyc_last) begin
                        rdata      <= {rdata[39:0], D_in};
                        bytes_left <= bytes_left - 3'd1;
                    end
                end
                S_HOLD: begin
                    // Advance after the first high cycle so A settles before the next RD fall.
                    if (cyc_cnt == 4'(RD_HIGH_CYC - 1)) A <= A + 6'd1;
                end
                default: ;
            endcase
        end
    end

    // Bus-facing outputs registered from next_state so RD and D_oe cannot glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RD      <= 1'b1;
            D_oe    <= 1'b1;
            bus_req <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            RD      <= (next_state != S_STROBE);
            D_oe    <= !(next_state inside {S_TURN, S_STROBE, S_HOLD});
            bus_req <= (next_state inside {S_REQ, S_TURN, S_STROBE, S_HOLD});
            busy    <= (next_state != S_IDLE);
            done    <= (next_state == S_DONE);
        end
    end

endmodule

// File: tb/tb_ad9854_reg_reader.sv
// Directed bench for ad9854_reg_reader: a register-file model answers RD
// strobes, monitors log RD falls, and each task checks one scenario.
module tb_ad9854_reg_reader;

    localparam int TURN_CYC    = 1;
    localparam int RD_LOW_CYC  = 3;
    localparam int RD_HIGH_CYC = 2;
    localparam int BYTE_CYC    = RD_LOW_CYC + RD_HIGH_CYC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  base_addr = '0;
    logic [2:0]  byte_cnt = '0;
    logic        bus_req;
    logic        bus_gnt = 1'b0;
    logic [5:0]  A;
    logic        RD;
    logic [7:0]  D_in;
    logic        D_oe;
    logic        busy;
    logic        done;
    logic [47:0] rdata;

    logic [7:0]  mem [64];

    int n_checks = 0;
    int n_fails  = 0;

    int edge_cnt    = 0;
    int rd_falls    = 0;
    int done_pulses = 0;
    int oe_viol     = 0;
    int bad_low     = 0;
    int low_run     = 0;
    logic [5:0] addr_log [$];

    ad9854_reg_reader #(
        .TURN_CYC   (TURN_CYC),
        .RD_LOW_CYC (RD_LOW_CYC),
        .RD_HIGH_CYC(RD_HIGH_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base_addr(base_addr),
        .byte_cnt (byte_cnt),
        .bus_req  (bus_req),
        .bus_gnt  (bus_gnt),
        .A        (A),
        .RD       (RD),
        .D_in     (D_in),
        .D_oe     (D_oe),
        .busy     (busy),
        .done     (done),
        .rdata    (rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    // Register-file model: drives data only while RD is low.
    assign D_in = RD ? 8'h00 : mem[A];

    // Log the address presented at each RD fall.
    always @(negedge RD) begin
        rd_falls++;
        addr_log.push_back(A);
    end

    // Per-cycle protocol monitors.
    always @(negedge clk) begin
        if (done === 1'b1) done_pulses++;
        if (RD === 1'b0 && D_oe !== 1'b0) oe_viol++;
        if (RD === 1'b0) begin
            low_run++;
        end else begin
            if (low_run != 0 && low_run != RD_LOW_CYC) bad_low++;
            low_run = 0;
        end
    end

    task automatic start_read(input logic [5:0] base, input logic [2:0] cnt, output int s_edge);
        @(negedge clk);
        base_addr = base;
        byte_cnt  = cnt;
        start     = 1'b1;
        s_edge    = edge_cnt + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, output int d_edge);
        d_edge = -1;
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) begin
                d_edge = edge_cnt;
                break;
            end
            @(negedge clk);
        end
        if (d_edge < 0) begin
            $display("FAIL %s_timeout: done not seen within %0d cycles", name, budget);
            n_fails++;
            n_checks++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        if ({bus_req, A, RD, D_oe, busy, done} !== {1'b0, 6'h00, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            $display("FAIL reset_ctrl: got req=%b A=%h RD=%b oe=%b busy=%b done=%b required 0 00 1 1 0 0",
                     bus_req, A, RD, D_oe, busy, done);
            n_fails++;
        end
        n_checks++;
        if (rdata !== 48'h0) begin
            $display("FAIL reset_rdata: got %h required 0", rdata);
            n_fails++;
        end
        n_checks++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_ftw();
        int s, d, f0, q0, p0, o0, b0, bad_a;
        bus_gnt = 1'b1;
        f0 = rd_falls; q0 = addr_log.size(); p0 = done_pulses; o0 = oe_viol; b0 = bad_low;
        start_read(6'h04, 3'd6, s);
        wait_done("ftw", 100, d);
        if (d !== s + 1 + 31) begin
            $display("FAIL ftw_latency: done at edge %0d required %0d", d, s + 32);
            n_fails++;
        end
        n_checks++;
        if (rdata !== 48'h0123_4567_89AB) begin
            $display("FAIL ftw_rdata: got %h required 0123456789ab", rdata);
            n_fails++;
        end
        n_checks++;
        @(negedge clk);
        if (done !== 1'b0 || busy !== 1'b0 || bus_req !== 1'b0 || D_oe !== 1'b1) begin
            $display("FAIL ftw_after_done: done=%b busy=%b req=%b oe=%b required 0 0 0 1", done, busy, bus_req, D_oe);
            n_fails++;
        end
        n_checks++;
        if (rd_falls - f0 !== 6) begin
            $display("FAIL ftw_rd_pulses: got %0d required 6", rd_falls - f0);
            n_fails++;
        end
        n_checks++;
        bad_a = 0;
        for (int i = 0; i < 6; i++) begin
            logic [5:0] ea;
            ea = 6'h04 + 6'(i);
            if (q0 + i >= addr_log.size() || addr_log[q0 + i] !== ea) bad_a++;
        end
        if (bad_a != 0) begin
            $display("FAIL ftw_addr_seq: %0d of 6 addresses wrong, required 04..09", bad_a);
            n_fails++;
        end
        n_checks++;
        if (oe_viol - o0 != 0 || bad_low - b0 != 0) begin
            $display("FAIL ftw_strobe_shape: oe_viol=%0d bad_low=%0d required 0 0", oe_viol - o0, bad_low - b0);
            n_fails++;
        end
        n_checks++;
        if (done_pulses - p0 != 1) begin
            $display("FAIL ftw_done_pulses: got %0d required 1", done_pulses - p0);
            n_fails++;
        end
        n_checks++;
    endtask

    task automatic test_short_read();
        int s, d, f0;
        f0 = rd_falls;
        start_read(6'h1D, 3'd2, s);
        wait_done("short", 60, d);
        if (d !== s + 1 + TURN_CYC + 2 * BYTE_CYC) begin
            $display("FAIL short_latency: done at edge %0d required %0d", d, s + 1 + TURN_CYC + 2 * BYTE_CYC);
            n_fails++;
        end
        n_checks++;
        if (rdata !== 48'h0000_0000_1064) begin
            $display("FAIL short_rdata: got %h required 000000001064", rdata);
            n_fails++;
        end
        n_checks++;
        @(negedge clk);
        if (rd_falls - f0 !== 2) begin
            $display("FAIL short_rd_pulses: got %0d required 2", rd_falls - f0);
            n_fails++;
        end
        n_checks++;
    endtask

    task automatic test_wrap_clamp();
        int s, d, f0, q0, bad_a;
        logic [5:0] ea;
        f0 = rd_falls; q0 = addr_log.size();
        start_read(6'h3E, 3'd7, s);
        wait_done("wrap", 100, d);
        if (rdata !== 48'hA1B2_C3D4_E5F6) begin
            $display("FAIL wrap_rdata: got %h required a1b2c3d4e5f6", rdata);
            n_fails++;
        end
        n_checks++;
        @(negedge clk);
        if (rd_falls - f0 !== 6) begin
            $display("FAIL wrap_rd_pulses: got %0d required 6", rd_falls - f0);
            n_fails++;
        end
        n_checks++;
        bad_a = 0;
        ea = 6'h3E;
        for (int i = 0; i < 6; i++) begin
            if (q0 + i >= addr_log.size() || addr_log[q0 + i] !== ea) bad_a++;
            ea = ea + 6'd1;
        end
        if (bad_a != 0) begin
            $display("FAIL wrap_addr_seq: %0d of 6 addresses wrong, required 3e 3f 00 01 02 03", bad_a);
            n_fails++;
        end
        n_checks++;
    endtask

    task automatic test_handshake();
        int s, d, g, f0, p0, bad_wait;
        bus_gnt = 1'b0;
        f0 = rd_falls; p0 = done_pulses;
        start_read(6'h1D, 3'd2, s);
        bad_wait = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus_req !== 1'b1 || RD !== 1'b1 || D_oe !== 1'b1 || busy !== 1'b1) bad_wait++;
            // A second request while busy must be dropped.
            if (i == 5) begin
                base_addr = 6'h04;
                byte_cnt  = 3'd6;
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (bad_wait != 0) begin
            $display("FAIL hs_wait_state: %0d of 20 wait cycles wrong, required req=1 RD=1 oe=1 busy=1", bad_wait);
            n_fails++;
        end
        n_checks++;
        bus_gnt = 1'b1;
        g = edge_cnt + 1;
        wait_done("hs", 60, d);
        if (d !== g + TURN_CYC + 2 * BYTE_CYC) begin
            $display("FAIL hs_latency: done at edge %0d required %0d", d, g + TURN_CYC + 2 * BYTE_CYC);
            n_fails++;
        end
        n_checks++;
        if (rdata !== 48'h0000_0000_1064) begin
            $display("FAIL hs_rdata: got %h required 000000001064", rdata);
            n_fails++;
        end
        n_checks++;
        repeat (10) @(negedge clk);
        if (rd_falls - f0 !== 2 || done_pulses - p0 !== 1 || busy !== 1'b0) begin
            $display("FAIL hs_no_queue: rd=%0d done=%0d busy=%b required 2 1 0", rd_falls - f0, done_pulses - p0, busy);
            n_fails++;
        end
        n_checks++;
    endtask

    task automatic test_reset_mid_read();
        int s, d, f0, p0, waited;
        bus_gnt = 1'b1;
        f0 = rd_falls; p0 = done_pulses;
        start_read(6'h04, 3'd6, s);
        waited = 0;
        while (rd_falls - f0 < 3 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (RD !== 1'b0) begin
            $display("FAIL rst_mid_in_strobe: RD=%b required 0 before reset (falls=%0d)", RD, rd_falls - f0);
            n_fails++;
        end
        n_checks++;
        #1 rst_n = 1'b0;
        #1;
        if ({RD, D_oe, bus_req, busy, done} !== 5'b11000 || A !== 6'h00 || rdata !== 48'h0) begin
            $display("FAIL rst_mid_async: RD=%b oe=%b req=%b busy=%b done=%b A=%h rdata=%h required 1 1 0 0 0 00 0",
                     RD, D_oe, bus_req, busy, done, A, rdata);
            n_fails++;
        end
        n_checks++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        if (done_pulses - p0 !== 0) begin
            $display("FAIL rst_mid_no_done: got %0d done pulses required 0", done_pulses - p0);
            n_fails++;
        end
        n_checks++;
        start_read(6'h04, 3'd6, s);
        wait_done("rst_fresh", 100, d);
        if (rdata !== 48'h0123_4567_89AB) begin
            $display("FAIL rst_fresh_rdata: got %h required 0123456789ab", rdata);
            n_fails++;
        end
        n_checks++;
        @(negedge clk);
    endtask

    task automatic test_zero_count();
        int s, f0;
        f0 = rd_falls;
        start_read(6'h10, 3'd0, s);
        if (done !== 1'b1 || edge_cnt !== s) begin
            $display("FAIL zero_done: done=%b at edge %0d required 1 at edge %0d", done, edge_cnt, s);
            n_fails++;
        end
        n_checks++;
        if (rdata !== 48'h0 || bus_req !== 1'b0) begin
            $display("FAIL zero_state: rdata=%h req=%b required 0 0", rdata, bus_req);
            n_fails++;
        end
        n_checks++;
        @(negedge clk);
        if (done !== 1'b0 || bus_req !== 1'b0 || rd_falls - f0 !== 0) begin
            $display("FAIL zero_after: done=%b req=%b rd=%0d required 0 0 0", done, bus_req, rd_falls - f0);
            n_fails++;
        end
        n_checks++;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        mem[6'h04] = 8'h01; mem[6'h05] = 8'h23; mem[6'h06] = 8'h45;
        mem[6'h07] = 8'h67; mem[6'h08] = 8'h89; mem[6'h09] = 8'hAB;
        mem[6'h1D] = 8'h10; mem[6'h1E] = 8'h64;
        mem[6'h3E] = 8'hA1; mem[6'h3F] = 8'hB2; mem[6'h00] = 8'hC3;
        mem[6'h01] = 8'hD4; mem[6'h02] = 8'hE5; mem[6'h03] = 8'hF6;

        test_reset();
        test_full_ftw();
        test_short_read();
        test_wrap_clamp();
        test_handshake();
        test_reset_mid_read();
        test_zero_count();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
